// File: rtl/scr1_mprf_wb_pkg.sv
// Shared types and constants for the MPRF write-back controller.
package scr1_mprf_wb_pkg;

  localparam int SCR1_MPRF_REGS = 32;

  typedef enum logic [1:0] {
    WB_SRC_NONE,
    WB_SRC_EXU,
    WB_SRC_LSU,
    WB_SRC_MDU
  } type_scr1_wb_src_e;

  // LSU and MDU results retire a scoreboard entry; EXU results never do.
  function automatic logic wb_src_is_long(input type_scr1_wb_src_e src);
    return (src == WB_SRC_LSU) || (src == WB_SRC_MDU);
  endfunction

endpackage

// File: rtl/scr1_pipe_mprf_sb.sv
// Busy-register scoreboard: tracks destinations of long-latency results,
// flags RAW/WAW hazards at issue and records retires to non-busy registers.
module scr1_pipe_mprf_sb
  import scr1_mprf_wb_pkg::*;
#(
  parameter int AW = 5
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          iss_vld_i,
  input  logic [AW-1:0] iss_rs1_addr_i,
  input  logic [AW-1:0] iss_rs2_addr_i,
  input  logic [AW-1:0] iss_rd_addr_i,
  input  logic          iss_rd_we_i,
  input  logic          iss_long_i,
  input  logic          clr_vld_i,
  input  logic [AW-1:0] clr_addr_i,
  output logic          hazard_o,
  output logic          err_o
);

  // Bit 0 is kept at zero so x0 always looks free.
  logic [SCR1_MPRF_REGS-1:0] busy_q, busy_d;
  logic                      err_q, err_d;
  logic                      rs1_busy, rs2_busy, rd_busy;
  logic                      set_en, clr_en;

  // Hazard lookup on registered state only (no same-cycle clear bypass).
  always_comb begin
    rs1_busy = (iss_rs1_addr_i != '0) && busy_q[iss_rs1_addr_i];
    rs2_busy = (iss_rs2_addr_i != '0) && busy_q[iss_rs2_addr_i];
    rd_busy  = (iss_rd_addr_i  != '0) && busy_q[iss_rd_addr_i];
    hazard_o = !rst && iss_vld_i && (rs1_busy || rs2_busy || (iss_rd_we_i && rd_busy));
  end

  // Set on an accepted long issue, clear on a retiring LSU/MDU write.
  always_comb begin
    set_en = iss_vld_i && !hazard_o && iss_rd_we_i && iss_long_i && (iss_rd_addr_i != '0);
    clr_en = clr_vld_i && (clr_addr_i != '0);
    busy_d = busy_q;
    if (clr_en) busy_d[clr_addr_i] = 1'b0;
    if (set_en) busy_d[iss_rd_addr_i] = 1'b1;
    busy_d[0] = 1'b0;
    err_d = err_q | (clr_en && !busy_q[clr_addr_i]);
  end

  // Scoreboard and sticky error state.
  always_ff @(posedge clk) begin
    if (rst) begin
      busy_q <= '0;
      err_q  <= 1'b0;
    end else begin
      busy_q <= busy_d;
      err_q  <= err_d;
    end
  end

  assign err_o = err_q;

endmodule

// File: rtl/scr1_pipe_mprf_wb_ctrl.sv
// MPRF write-port arbiter for EXU/LSU/MDU results with an EXU starvation
// guard, plus the busy-register scoreboard driving the issue stall.
module scr1_pipe_mprf_wb_ctrl
  import scr1_mprf_wb_pkg::*;
#(
  parameter int STARVE_LIM = 4,
  parameter int XLEN       = 32,
  parameter int AW         = 5
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            iss_vld_i,
  input  logic [AW-1:0]   iss_rs1_addr_i,
  input  logic [AW-1:0]   iss_rs2_addr_i,
  input  logic [AW-1:0]   iss_rd_addr_i,
  input  logic            iss_rd_we_i,
  input  logic            iss_long_i,
  output logic            iss_hazard_o,
  input  logic            exu_wb_vld_i,
  input  logic [AW-1:0]   exu_wb_addr_i,
  input  logic [XLEN-1:0] exu_wb_data_i,
  output logic            exu_wb_rdy_o,
  input  logic            lsu_wb_vld_i,
  input  logic [AW-1:0]   lsu_wb_addr_i,
  input  logic [XLEN-1:0] lsu_wb_data_i,
  output logic            lsu_wb_rdy_o,
  input  logic            mdu_wb_vld_i,
  input  logic [AW-1:0]   mdu_wb_addr_i,
  input  logic [XLEN-1:0] mdu_wb_data_i,
  output logic            mdu_wb_rdy_o,
  output logic            mprf_w_req_o,
  output logic [AW-1:0]   mprf_rd_addr_o,
  output logic [XLEN-1:0] mprf_rd_data_o,
  output logic            sb_err_o
);

  localparam int            SW         = $clog2(STARVE_LIM + 1);
  localparam logic [SW-1:0] STARVE_MAX = SW'(STARVE_LIM);

  type_scr1_wb_src_e grant;
  logic [SW-1:0]     starve_q, starve_d;
  logic              starve_force;

  assign starve_force = (starve_q == STARVE_MAX);

  // Fixed priority LSU > MDU > EXU, except EXU jumps ahead once starved.
  always_comb begin
    grant = WB_SRC_NONE;
    if (!rst) begin
      if (starve_force && exu_wb_vld_i) grant = WB_SRC_EXU;
      else if (lsu_wb_vld_i)            grant = WB_SRC_LSU;
      else if (mdu_wb_vld_i)            grant = WB_SRC_MDU;
      else if (exu_wb_vld_i)            grant = WB_SRC_EXU;
    end
  end

  // Ready strobes and write-port mux; x0 writes are accepted but dropped.
  always_comb begin
    exu_wb_rdy_o   = (grant == WB_SRC_EXU);
    lsu_wb_rdy_o   = (grant == WB_SRC_LSU);
    mdu_wb_rdy_o   = (grant == WB_SRC_MDU);
    mprf_rd_addr_o = '0;
    mprf_rd_data_o = '0;
    unique case (grant)
      WB_SRC_EXU: begin mprf_rd_addr_o = exu_wb_addr_i; mprf_rd_data_o = exu_wb_data_i; end
      WB_SRC_LSU: begin mprf_rd_addr_o = lsu_wb_addr_i; mprf_rd_data_o = lsu_wb_data_i; end
      WB_SRC_MDU: begin mprf_rd_addr_o = mdu_wb_addr_i; mprf_rd_data_o = mdu_wb_data_i; end
      default:    ;
    endcase
    mprf_w_req_o = (grant != WB_SRC_NONE) && (mprf_rd_addr_o != '0);
  end

  // Count consecutive EXU denials, saturating; any grant or idle EXU clears.
  always_comb begin
    starve_d = '0;
    if (exu_wb_vld_i && !exu_wb_rdy_o)
      starve_d = starve_force ? STARVE_MAX : starve_q + SW'(1);
  end

  // Starvation counter register.
  always_ff @(posedge clk) begin
    if (rst) starve_q <= '0;
    else     starve_q <= starve_d;
  end

  scr1_pipe_mprf_sb #(.AW(AW)) u_sb (
    .clk            (clk),
    .rst            (rst),
    .iss_vld_i      (iss_vld_i),
    .iss_rs1_addr_i (iss_rs1_addr_i),
    .iss_rs2_addr_i (iss_rs2_addr_i),
    .iss_rd_addr_i  (iss_rd_addr_i),
    .iss_rd_we_i    (iss_rd_we_i),
    .iss_long_i     (iss_long_i),
    .clr_vld_i      (wb_src_is_long(grant)),
    .clr_addr_i     (mprf_rd_addr_o),
    .hazard_o       (iss_hazard_o),
    .err_o          (sb_err_o)
  );

endmodule

// File: tb/tb_scr1_pipe_mprf_wb_ctrl.sv
// Self-checking bench for scr1_pipe_mprf_wb_ctrl: directed scenarios plus a
// randomized run against a behavioural model of arbitration and scoreboard.
module tb_scr1_pipe_mprf_wb_ctrl;

  localparam int LIM = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        iss_vld_i, iss_rd_we_i, iss_long_i, iss_hazard_o;
  logic [4:0]  iss_rs1_addr_i, iss_rs2_addr_i, iss_rd_addr_i;
  logic        exu_wb_vld_i, lsu_wb_vld_i, mdu_wb_vld_i;
  logic [4:0]  exu_wb_addr_i, lsu_wb_addr_i, mdu_wb_addr_i;
  logic [31:0] exu_wb_data_i, lsu_wb_data_i, mdu_wb_data_i;
  logic        exu_wb_rdy_o, lsu_wb_rdy_o, mdu_wb_rdy_o;
  logic        mprf_w_req_o, sb_err_o;
  logic [4:0]  mprf_rd_addr_o;
  logic [31:0] mprf_rd_data_o;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  scr1_pipe_mprf_wb_ctrl #(.STARVE_LIM(LIM), .XLEN(32), .AW(5)) dut (
    .clk(clk), .rst(rst),
    .iss_vld_i(iss_vld_i), .iss_rs1_addr_i(iss_rs1_addr_i), .iss_rs2_addr_i(iss_rs2_addr_i),
    .iss_rd_addr_i(iss_rd_addr_i), .iss_rd_we_i(iss_rd_we_i), .iss_long_i(iss_long_i),
    .iss_hazard_o(iss_hazard_o),
    .exu_wb_vld_i(exu_wb_vld_i), .exu_wb_addr_i(exu_wb_addr_i), .exu_wb_data_i(exu_wb_data_i),
    .exu_wb_rdy_o(exu_wb_rdy_o),
    .lsu_wb_vld_i(lsu_wb_vld_i), .lsu_wb_addr_i(lsu_wb_addr_i), .lsu_wb_data_i(lsu_wb_data_i),
    .lsu_wb_rdy_o(lsu_wb_rdy_o),
    .mdu_wb_vld_i(mdu_wb_vld_i), .mdu_wb_addr_i(mdu_wb_addr_i), .mdu_wb_data_i(mdu_wb_data_i),
    .mdu_wb_rdy_o(mdu_wb_rdy_o),
    .mprf_w_req_o(mprf_w_req_o), .mprf_rd_addr_o(mprf_rd_addr_o), .mprf_rd_data_o(mprf_rd_data_o),
    .sb_err_o(sb_err_o)
  );

  // ---------------- behavioural reference model ----------------
  bit [31:0] m_busy;
  bit        m_err;
  int        m_starve;

  // Winner: 0 none, 1 EXU, 2 LSU, 3 MDU.
  function automatic int model_win();
    if (rst) return 0;
    if (m_starve == LIM && exu_wb_vld_i) return 1;
    if (lsu_wb_vld_i) return 2;
    if (mdu_wb_vld_i) return 3;
    if (exu_wb_vld_i) return 1;
    return 0;
  endfunction

  function automatic bit reg_busy(input logic [4:0] a);
    return (a != 0) && m_busy[a];
  endfunction

  function automatic bit model_hz();
    return !rst && iss_vld_i && (reg_busy(iss_rs1_addr_i) || reg_busy(iss_rs2_addr_i) ||
                                 (iss_rd_we_i && reg_busy(iss_rd_addr_i)));
  endfunction

  function automatic logic [42:0] exp_vec();
    int w;
    logic [4:0]  a;
    logic [31:0] d;
    w = model_win();
    a = 0;
    d = 0;
    if (w == 1) begin a = exu_wb_addr_i; d = exu_wb_data_i; end
    if (w == 2) begin a = lsu_wb_addr_i; d = lsu_wb_data_i; end
    if (w == 3) begin a = mdu_wb_addr_i; d = mdu_wb_data_i; end
    return {w == 1, w == 2, w == 3, (w != 0) && (a != 0), a, d, model_hz(), m_err};
  endfunction

  always @(posedge clk) begin
    int w;
    bit hz;
    logic [4:0] a;
    w  = model_win();
    hz = model_hz();
    a  = (w == 2) ? lsu_wb_addr_i : mdu_wb_addr_i;
    if (rst) begin
      m_busy = '0; m_err = 0; m_starve = 0;
    end else begin
      if (w >= 2 && a != 0) begin
        if (!m_busy[a]) m_err = 1;
        m_busy[a] = 0;
      end
      if (iss_vld_i && !hz && iss_rd_we_i && iss_long_i && iss_rd_addr_i != 0)
        m_busy[iss_rd_addr_i] = 1;
      if (exu_wb_vld_i && w != 1) m_starve = (m_starve < LIM) ? m_starve + 1 : LIM;
      else                        m_starve = 0;
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic idle();
    iss_vld_i = 0; iss_rs1_addr_i = 0; iss_rs2_addr_i = 0; iss_rd_addr_i = 0;
    iss_rd_we_i = 0; iss_long_i = 0;
    exu_wb_vld_i = 0; exu_wb_addr_i = 0; exu_wb_data_i = 0;
    lsu_wb_vld_i = 0; lsu_wb_addr_i = 0; lsu_wb_data_i = 0;
    mdu_wb_vld_i = 0; mdu_wb_addr_i = 0; mdu_wb_data_i = 0;
  endtask

  task automatic next();
    @(negedge clk);
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    rst = 1; idle();
    next(); next();
    iss_vld_i = 1; iss_rs1_addr_i = 3;
    exu_wb_vld_i = 1; exu_wb_addr_i = 4; lsu_wb_vld_i = 1; lsu_wb_addr_i = 5;
    mdu_wb_vld_i = 1; mdu_wb_addr_i = 6;
    #1;
    checks++;
    if ({exu_wb_rdy_o, lsu_wb_rdy_o, mdu_wb_rdy_o, mprf_w_req_o, iss_hazard_o, sb_err_o} !== 6'b0) begin
      failures++;
      $display("FAIL reset_outputs got=%b exp=000000",
               {exu_wb_rdy_o, lsu_wb_rdy_o, mdu_wb_rdy_o, mprf_w_req_o, iss_hazard_o, sb_err_o});
    end
    next();
    idle(); rst = 0;
    #1;
    checks++;
    if ({mprf_w_req_o, mprf_rd_addr_o, mprf_rd_data_o} !== 38'b0) begin
      failures++;
      $display("FAIL idle_mux got=%b/%h/%h exp=0/00/00000000", mprf_w_req_o, mprf_rd_addr_o, mprf_rd_data_o);
    end
    next();
  endtask

  task automatic test_exu_single();
    exu_wb_vld_i = 1; exu_wb_addr_i = 5; exu_wb_data_i = 32'hDEAD_BEEF;
    #1;
    checks++;
    if ({exu_wb_rdy_o, mprf_w_req_o, mprf_rd_addr_o, mprf_rd_data_o} !== {1'b1, 1'b1, 5'd5, 32'hDEAD_BEEF}) begin
      failures++;
      $display("FAIL exu_single got rdy=%b req=%b a=%0d d=%h exp 1 1 5 deadbeef",
               exu_wb_rdy_o, mprf_w_req_o, mprf_rd_addr_o, mprf_rd_data_o);
    end
    next(); idle();
  endtask

  task automatic test_busy_hazard();
    iss_vld_i = 1; iss_rd_addr_i = 7; iss_rd_we_i = 1; iss_long_i = 1;
    #1;
    checks++;
    if (iss_hazard_o !== 1'b0) begin failures++; $display("FAIL issue_rd7 hazard got=%b exp=0", iss_hazard_o); end
    next(); idle();
    iss_vld_i = 1; iss_rs1_addr_i = 7;
    #1;
    checks++;
    if (iss_hazard_o !== 1'b1) begin failures++; $display("FAIL raw_rs1_7 hazard got=%b exp=1", iss_hazard_o); end
    iss_rs1_addr_i = 0; iss_rd_addr_i = 7; iss_rd_we_i = 1;
    #1;
    checks++;
    if (iss_hazard_o !== 1'b1) begin failures++; $display("FAIL waw_rd_7 hazard got=%b exp=1", iss_hazard_o); end
    iss_rd_addr_i = 0; iss_rd_we_i = 0; iss_rs1_addr_i = 7;
    lsu_wb_vld_i = 1; lsu_wb_addr_i = 7; lsu_wb_data_i = 32'h1234_5678;
    #1;
    checks++;
    if ({lsu_wb_rdy_o, mprf_w_req_o, mprf_rd_addr_o, iss_hazard_o} !== {1'b1, 1'b1, 5'd7, 1'b1}) begin
      failures++;
      $display("FAIL lsu_clear7 got rdy=%b req=%b a=%0d hz=%b exp 1 1 7 1",
               lsu_wb_rdy_o, mprf_w_req_o, mprf_rd_addr_o, iss_hazard_o);
    end
    next();
    lsu_wb_vld_i = 0;
    #1;
    checks++;
    if ({iss_hazard_o, sb_err_o} !== 2'b00) begin
      failures++; $display("FAIL after_clear7 got hz/err=%b exp=00", {iss_hazard_o, sb_err_o});
    end
    next(); idle();
  endtask

  task automatic test_starvation();
    bit       lsu_v [6] = '{1, 0, 1, 1, 1, 1};
    bit [2:0] exp_g [6] = '{3'b010, 3'b001, 3'b010, 3'b010, 3'b100, 3'b010};
    exu_wb_vld_i = 1; exu_wb_addr_i = 12; exu_wb_data_i = 32'hA5A5_0001;
    mdu_wb_vld_i = 1; mdu_wb_addr_i = 0;  mdu_wb_data_i = 32'h0000_00DD;
    lsu_wb_addr_i = 0; lsu_wb_data_i = 32'h0000_00CC;
    for (int c = 0; c < 6; c++) begin
      lsu_wb_vld_i = lsu_v[c];
      #1;
      checks++;
      if ({exu_wb_rdy_o, lsu_wb_rdy_o, mdu_wb_rdy_o} !== exp_g[c]) begin
        failures++;
        $display("FAIL starve_cycle%0d grant(e,l,m) got=%b exp=%b", c + 1,
                 {exu_wb_rdy_o, lsu_wb_rdy_o, mdu_wb_rdy_o}, exp_g[c]);
      end
      next();
    end
    idle();
    next();
  endtask

  task automatic test_x0_write();
    mdu_wb_vld_i = 1; mdu_wb_addr_i = 0; mdu_wb_data_i = 32'hFFFF_0000;
    #1;
    checks++;
    if ({mdu_wb_rdy_o, mprf_w_req_o} !== 2'b10) begin
      failures++; $display("FAIL mdu_x0 rdy/req got=%b exp=10", {mdu_wb_rdy_o, mprf_w_req_o});
    end
    next(); idle();
    iss_vld_i = 1; iss_rs1_addr_i = 0; iss_rs2_addr_i = 0; iss_rd_addr_i = 0; iss_rd_we_i = 1;
    #1;
    checks++;
    if ({iss_hazard_o, sb_err_o} !== 2'b00) begin
      failures++; $display("FAIL after_x0 hz/err got=%b exp=00", {iss_hazard_o, sb_err_o});
    end
    next(); idle();
  endtask

  task automatic test_err_sticky();
    lsu_wb_vld_i = 1; lsu_wb_addr_i = 9; lsu_wb_data_i = 32'h0BAD_F00D;
    #1;
    checks++;
    if ({lsu_wb_rdy_o, mprf_w_req_o, mprf_rd_addr_o, sb_err_o} !== {1'b1, 1'b1, 5'd9, 1'b0}) begin
      failures++;
      $display("FAIL lsu_nonbusy9 got rdy=%b req=%b a=%0d err=%b exp 1 1 9 0",
               lsu_wb_rdy_o, mprf_w_req_o, mprf_rd_addr_o, sb_err_o);
    end
    next(); idle();
    for (int c = 0; c < 3; c++) begin
      #1;
      checks++;
      if (sb_err_o !== 1'b1) begin failures++; $display("FAIL err_sticky%0d got=%b exp=1", c, sb_err_o); end
      next();
    end
  endtask

  task automatic test_reset_mid();
    iss_vld_i = 1; iss_rd_addr_i = 3; iss_rd_we_i = 1; iss_long_i = 1;
    next(); idle();
    iss_vld_i = 1; iss_rs1_addr_i = 3;
    #1;
    checks++;
    if (iss_hazard_o !== 1'b1) begin failures++; $display("FAIL busy3_set hazard got=%b exp=1", iss_hazard_o); end
    rst = 1; lsu_wb_vld_i = 1; lsu_wb_addr_i = 3; lsu_wb_data_i = 32'h3333_3333;
    #1;
    checks++;
    if ({lsu_wb_rdy_o, mprf_w_req_o, iss_hazard_o} !== 3'b000) begin
      failures++; $display("FAIL rst_mid rdy/req/hz got=%b exp=000", {lsu_wb_rdy_o, mprf_w_req_o, iss_hazard_o});
    end
    next();
    rst = 0; lsu_wb_vld_i = 0;
    #1;
    checks++;
    if ({iss_hazard_o, sb_err_o} !== 2'b00) begin
      failures++; $display("FAIL post_rst hz/err got=%b exp=00", {iss_hazard_o, sb_err_o});
    end
    next(); idle();
  endtask

  task automatic test_random();
    bit          pv [3];
    logic [4:0]  pa [3];
    logic [31:0] pd [3];
    logic [42:0] act, exp;
    int          w, errs;
    errs = 0;
    for (int s = 0; s < 3; s++) pv[s] = 0;
    for (int c = 0; c < 600; c++) begin
      rst = ($urandom_range(0, 79) == 0);
      for (int s = 0; s < 3; s++) begin
        if (!pv[s]) begin
          pv[s] = $urandom_range(0, 1);
          pa[s] = 5'($urandom_range(0, 7));
          pd[s] = $urandom;
          // Long sources mostly retire a register that is actually busy.
          if (s > 0 && $urandom_range(0, 3) != 0) begin
            int st;
            bit found;
            st = $urandom_range(1, 7);
            found = 0;
            for (int k = 0; k < 7; k++) begin
              int idx;
              idx = 1 + ((st - 1 + k) % 7);
              if (!found && m_busy[idx]) begin pa[s] = 5'(idx); found = 1; end
            end
          end
        end
      end
      exu_wb_vld_i = pv[0]; exu_wb_addr_i = pa[0]; exu_wb_data_i = pd[0];
      lsu_wb_vld_i = pv[1]; lsu_wb_addr_i = pa[1]; lsu_wb_data_i = pd[1];
      mdu_wb_vld_i = pv[2]; mdu_wb_addr_i = pa[2]; mdu_wb_data_i = pd[2];
      iss_vld_i      = $urandom_range(0, 1);
      iss_rs1_addr_i = 5'($urandom_range(0, 7));
      iss_rs2_addr_i = 5'($urandom_range(0, 7));
      iss_rd_addr_i  = 5'($urandom_range(0, 7));
      iss_rd_we_i    = $urandom_range(0, 1);
      iss_long_i     = $urandom_range(0, 1);
      #1;
      exp = exp_vec();
      act = {exu_wb_rdy_o, lsu_wb_rdy_o, mdu_wb_rdy_o, mprf_w_req_o, mprf_rd_addr_o, mprf_rd_data_o,
             iss_hazard_o, sb_err_o};
      checks++;
      if (act !== exp) begin
        failures++;
        if (errs < 10)
          $display("FAIL random_cycle%0d got=%h exp=%h (rdy e/l/m, req, addr, data, hz, err)", c, act, exp);
        errs++;
      end
      w = model_win();
      if (rst) for (int s = 0; s < 3; s++) pv[s] = 0;
      else if (w != 0) pv[w - 1] = 0;
      next();
    end
    rst = 0; idle();
    next();
  endtask

  initial begin
    idle();
    test_reset();
    test_exu_single();
    test_busy_hazard();
    test_starvation();
    test_x0_write();
    test_err_sticky();
    test_reset_mid();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout bench did not complete");
    $fatal(1);
  end

endmodule
